// File: rtl/frv_pmul_pkg.sv
// Shared XCrypto packed-arithmetic definitions: pw lane encoding, op select, pmul FSM states.
package frv_pmul_pkg;

  typedef enum logic [1:0] {
    PW_32 = 2'b00,
    PW_16 = 2'b01,
    PW_8  = 2'b10,
    PW_4  = 2'b11
  } pw_e;

  typedef struct packed {
    logic clmul;
    logic hi;
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  function automatic logic [5:0] lane_w(input pw_e pw);
    case (pw)
      PW_32:   lane_w = 6'd32;
      PW_16:   lane_w = 6'd16;
      PW_8:    lane_w = 6'd8;
      default: lane_w = 6'd4;
    endcase
  endfunction

  function automatic logic [2:0] lane_log2(input pw_e pw);
    case (pw)
      PW_32:   lane_log2 = 3'd5;
      PW_16:   lane_log2 = 3'd4;
      PW_8:    lane_log2 = 3'd3;
      default: lane_log2 = 3'd2;
    endcase
  endfunction

  // One bit set at the LSB of every 2W-wide product field.
  function automatic logic [63:0] seg_lsb(input pw_e pw);
    logic [5:0] seg_m1;
    seg_m1 = {5'(lane_w(pw) - 6'd1), 1'b1};
    for (int j = 0; j < 64; j++) begin
      seg_lsb[j] = ((6'(j) & seg_m1) == 6'd0);
    end
  endfunction

endpackage

// File: rtl/frv_pmul_seg_add.sv
// 64-bit segmented adder / XOR; carries are killed at every 2W field boundary.
// Purely combinational.
module frv_pmul_seg_add
  import frv_pmul_pkg::*;
(
  input  logic [1:0]  pw,
  input  logic        clmul,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic [63:0] sum
);

  logic [63:0] lsb;
  logic        carry;

  always_comb begin
    lsb   = seg_lsb(pw_e'(pw));
    carry = 1'b0;
    sum   = '0;
    for (int j = 0; j < 64; j++) begin
      if (lsb[j]) carry = 1'b0;
      sum[j] = a[j] ^ b[j] ^ (carry & ~clmul);
      carry  = (a[j] & b[j]) | (carry & (a[j] ^ b[j]));
    end
  end

endmodule

// File: rtl/frv_pmul.sv
// Iterative packed-lane multiply / carry-less multiply, one multiplier bit per lane per cycle.
// Result after W cycles; holds out_valid/result under backpressure, no accept until back in IDLE.
module frv_pmul
  import frv_pmul_pkg::*;
(
  input  logic        g_clk,
  input  logic        g_rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  pw,
  input  logic        op_hi,
  input  logic        op_clmul,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result
);

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] mul_q, mul_d;
  logic [63:0] mcand_q, mcand_d;
  logic [63:0] acc_q, acc_d;
  pw_e         pw_q, pw_d;
  op_t         op_q, op_d;
  logic [31:0] result_q, result_d;

  logic        accept;
  logic [4:0]  k;
  logic [63:0] sel, addend, acc_sum, lsb_mask;
  logic [31:0] res_asm;
  int          sh, sh_in;

  assign accept = in_valid && (state_q == ST_IDLE) && !flush;

  // Per-lane bit-select: every bit of lane i's field sees multiplier bit W*i+k.
  always_comb begin
    sh       = int'(lane_log2(pw_q));
    k        = 5'(lane_w(pw_q) - 6'd1 - {1'b0, cnt_q});
    lsb_mask = seg_lsb(pw_q);
    sel      = '0;
    for (int j = 0; j < 64; j++) begin
      sel[j] = mul_q[5'(((j >> (sh + 1)) << sh) + int'(k))];
    end
    addend = mcand_q & sel;
  end

  frv_pmul_seg_add u_seg_add (
    .pw    (pw_q),
    .clmul (op_q.clmul),
    .a     (acc_q),
    .b     (addend),
    .sum   (acc_sum)
  );

  always_comb begin
    res_asm = '0;
    for (int j = 0; j < 32; j++) begin
      res_asm[j] = acc_sum[6'(((j >> sh) << (sh + 1)) + (j - ((j >> sh) << sh))
                              + (op_q.hi ? (1 << sh) : 0))];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mul_d    = mul_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    pw_d     = pw_q;
    op_d     = op_q;
    result_d = result_q;
    sh_in    = int'(lane_log2(pw_e'(pw)));
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          pw_d  = pw_e'(pw);
          op_d  = '{clmul: op_clmul, hi: op_hi};
          mul_d = rs2;
          acc_d = '0;
          cnt_d = 5'(lane_w(pw_e'(pw)) - 6'd1);
          for (int j = 0; j < 64; j++) begin
            if ((j - ((j >> (sh_in + 1)) << (sh_in + 1))) < (1 << sh_in))
              mcand_d[j] = rs1[5'(((j >> (sh_in + 1)) << sh_in)
                                  + (j - ((j >> (sh_in + 1)) << (sh_in + 1))))];
            else
              mcand_d[j] = 1'b0;
          end
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        acc_d   = acc_sum;
        mcand_d = (mcand_q << 1) & ~lsb_mask;
        if (cnt_q == 5'd0) begin
          result_d = res_asm;
          state_d  = ST_DONE;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  always_ff @(posedge g_clk) begin
    if (g_rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      mul_q    <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      pw_q     <= PW_32;
      op_q     <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mul_q    <= mul_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      pw_q     <= pw_d;
      op_q     <= op_d;
      result_q <= result_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;

endmodule

// File: doc/frv_pmul.md
# frv_pmul

Iterative packed-lane multiplier for the XCrypto packed-arithmetic group. It executes `xc.pmul.l`, `xc.pmul.h`, `xc.pclmul.l` and `xc.pclmul.h` on 32-bit operands split into lanes of width 32, 16, 8 or 4. It sits in the execute stage beside the single-cycle packed add/sub unit and uses the same `pw` lane encoding. Its result feeds the writeback result mux, and from there the RVFI trace that the per-instruction packed-arithmetic checkers compare against.

## Interface

Parameters:
- none. Lane widths are fixed by the `pw` encoding.

Ports:
- `g_clk` in 1: core clock, rising-edge.
- `g_rst` in 1: reset, synchronous, active-high.
- `flush` in 1: pipeline flush. Abandons any operation.
- `in_valid` in 1: operands and op present.
- `in_ready` out 1: unit can accept an operation (IDLE).
- `pw` in 2: lane width. 00=32, 01=16, 10=8, 11=4.
- `op_hi` in 1: 0 selects the low W bits of each lane product, 1 selects the high W bits.
- `op_clmul` in 1: 1 selects carry-less (XOR) accumulation, 0 selects integer addition.
- `rs1` in 32: multiplicand lanes.
- `rs2` in 32: multiplier lanes.
- `out_valid` out 1: `result` valid.
- `out_ready` in 1: consumer takes `result`.
- `result` out 32: packed result. Lane i occupies bits [W*i +: W].

## Operation

- All arithmetic is unsigned, per lane. There is no carry or XOR propagation across lane boundaries.
- On acceptance (`in_valid && in_ready`):
  - latch `pw`, `op_hi`, `op_clmul`.
  - latch `rs2` into the multiplier register.
  - place each rs1 lane, zero-extended to 2W bits, into a 64-bit multiplicand register. Lane i sits at bits [2W*i +: 2W].
  - clear the 64-bit accumulator.
  - load the iteration counter with W−1.
- BUSY iteration k (k = 0..W−1), for each lane i:
  - if multiplier bit [W*i + k] is set: acc_lane ← acc_lane + mcand_lane (or `^` when `op_clmul`), computed mod 2^(2W).
  - then mcand_lane ← mcand_lane << 1 within its 2W field; bits shifted out of the field are discarded.
- Result assembly: lane i = acc[2W*i +: W] when `op_hi`=0, acc[2W*i + W +: W] when `op_hi`=1.
- States and transitions:
  - IDLE: `in_ready`=1. Goes to BUSY on acceptance.
  - BUSY: count down. Goes to DONE after the iteration with counter = 0.
  - DONE: `out_valid`=1, `result` stable. Goes to IDLE on `out_valid && out_ready`.
- `in_ready` is 0 in BUSY and DONE. There is no same-cycle accept on the completion handshake; the next operation is accepted one cycle after the unit returns to IDLE.
- Flush: in any state, the next state is IDLE and `out_valid`=0. Flush has priority over acceptance and completion. An `in_valid` presented in the same cycle as `flush` is not accepted.
- Reset: has priority over flush. Applies from any state, including mid-iteration.
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `result`=0, accumulator and counter 0.
- Inputs are ignored outside IDLE; changing operands during BUSY has no effect.

## Timing

- Latency: acceptance edge, then W iteration edges. `out_valid` rises after the W-th iteration edge: 32/16/8/4 cycles for `pw` 00/01/10/11.
- `out_valid` and `result` hold for as long as `out_ready` stays low, with unbounded backpressure.
- Throughput: one operation per W+2 cycles when `out_ready` is held high.
- `result` is registered; there are no combinational paths from inputs to outputs.
- `in_ready` depends only on state.

## Structure

- Shared constants (in the common XCrypto header/package, also used by the add/sub unit and the checkers):
  - `pw` encodings and lane-width lookup.
  - op-select bit definitions.
  - FSM state encodings for this block.
- Sub-module `frv_pmul_seg_add`: 64-bit segmented adder/XOR with carry-kill at 2W boundaries selected by `pw`. It is combinational and instantiated once.
- Top level holds:
  - the FSM and counter.
  - the multiplier and multiplicand registers.
  - the per-lane bit-select mask.
  - result assembly.

## Test plan

- `pw`=00, mul.l, rs1=0x00000003, rs2=0x00000005 → `result`=0x0000000F; `out_valid` rises exactly 32 cycles after acceptance.
- `pw`=01, mul.h, rs1=0xFFFF0002, rs2=0xFFFF0003 → `result`=0xFFFE0000 after 16 cycles. This checks that no carry leaks across lanes.
- `pw`=10, clmul.l, rs1=rs2=0x03030303 → `result`=0x05050505 after 8 cycles.
- `pw`=11, mul.l, rs1=0xFFFFFFFF, rs2=0x22222222 → `result`=0xEEEEEEEE after 4 cycles. With `out_ready` held low for 10 cycles, `out_valid` and `result` stay stable and `in_ready` stays 0.
- `flush` at BUSY cycle 5 of a `pw`=00 op → IDLE next cycle, `out_valid` never rises. A following `pw`=11 op, rs1=0x00000002, rs2=0x00000003, mul.l → 0x00000006, with no residue from the flushed op.
- `g_rst` asserted mid-BUSY, and also simultaneously with `flush` and `in_valid` → all outputs at reset values next cycle, and the unit accepts normally afterwards.
